mygo_stage_word2bytes: RTL

MYGO_STAGE_WORD2BYTES -- requirements
Module: mygo_stage_word2bytes

---
 rtl/mygo_stage_word2bytes.sv | 85 ++++++++
 1 files changed

// File: rtl/mygo_stage_word2bytes.sv
// Word-to-byte serialiser: takes 32-bit words from an upstream FIFO, emits them as
// four bytes, and issues a single completion token after WORDS words.
module mygo_stage_word2bytes #(
  parameter int WORDS     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done_data,
  output logic        done_valid,
  input  logic        done_ready
);

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam logic [7:0] WORDS_C = 8'(WORDS);

  logic [1:0]  state;
  logic [31:0] hold;
  logic [1:0]  byte_idx;
  logic [7:0]  word_cnt;

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [1:0] pos;
    pos = (LSB_FIRST != 0) ? idx : (2'd3 - idx);
    case (pos)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_WAIT;
      hold     <= '0;
      byte_idx <= '0;
      word_cnt <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          // Only reachable with the quota already met when WORDS is 0.
          if (word_cnt == WORDS_C) begin
            state <= ST_DONE;
          end else if (in_valid) begin
            hold     <= in_data;
            byte_idx <= 2'd0;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              word_cnt <= word_cnt + 8'd1;
              state    <= ((word_cnt + 8'd1) == WORDS_C) ? ST_DONE : ST_WAIT;
            end
          end
        end
        ST_DONE: begin
          if (done_ready) state <= ST_HALT;
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  // The quota term keeps a zero-word configuration from ever handshaking a word.
  assign in_ready   = (state == ST_WAIT) && (word_cnt != WORDS_C) && !rst;
  assign out_valid  = (state == ST_SEND);
  assign out_data   = pick_byte(hold, byte_idx);
  assign done_valid = (state == ST_DONE);
  assign done_data  = (state == ST_DONE);

endmodule
